// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg : opcodes, width defaults and arbiter state encoding for the ALU.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int ALU_DATA_W = 16;
  localparam int ALU_OP_W   = 4;

  localparam logic [ALU_OP_W-1:0] OP_NOP = 4'b0000;
  localparam logic [ALU_OP_W-1:0] OP_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin grant, one-hot output, purely combinational.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);

  // On contention the requester that did not win last time goes first.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      if (req_valid == 2'b11) begin
        grant = last_grant ? 2'b01 : 2'b10;
      end else begin
        grant = req_valid;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter : arbitrates two requesters onto the shared ALU and returns
//               result/zero/err on a per-requester response handshake.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req0_opcode,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req1_opcode,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  logic              last_grant_q;
  logic              g_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q, err_q;

  logic [1:0]        grant;
  logic              accept, gidx, legal, rsp_done;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_a, sel_b;

  rr_arb2 u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .en         (state_q == ST_IDLE),
    .grant      (grant)
  );

  assign accept   = |grant;
  assign gidx     = grant[1];
  assign sel_op   = gidx ? req1_opcode : req0_opcode;
  assign sel_a    = gidx ? req1_a : req0_a;
  assign sel_b    = gidx ? req1_b : req0_b;
  assign legal    = (sel_op == OP_W'(OP_ADD)) || (sel_op == OP_W'(OP_SUB));
  assign rsp_done = (state_q == ST_RESPOND) && rsp_ready[g_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (accept) state_d = legal ? ST_ISSUE : ST_RESPOND;
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RESPOND;
      ST_RESPOND: if (rsp_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      g_q          <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        last_grant_q <= gidx;
        g_q          <= gidx;
        op_q         <= sel_op;
        a_q          <= sel_a;
        b_q          <= sel_b;
        // Unsupported ops never reach the ALU; answer with an error at once.
        if (!legal) begin
          result_q <= '0;
          zero_q   <= 1'b0;
          err_q    <= 1'b1;
        end
      end
      if (state_q == ST_CAPTURE) begin
        result_q <= alu_result;
        zero_q   <= alu_zero;
        err_q    <= 1'b0;
      end
    end
  end

  assign req_ready  = grant;
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESPOND) ? (g_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
  assign rsp_err    = err_q;
  assign alu_opcode = (state_q == ST_ISSUE) ? op_q : OP_W'(OP_NOP);
  assign alu_a      = (state_q == ST_ISSUE) ? a_q : '0;
  assign alu_b      = (state_q == ST_ISSUE) ? b_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter : directed, scoreboard-based bench for alu_arbiter with a
//                  behavioural one-cycle registered ALU.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_alu_arbiter;
  import alu_pkg::*;

  typedef struct {
    logic [1:0]  vld;
    logic [15:0] result;
    logic        zero;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [3:0]  req0_opcode = 4'h0, req1_opcode = 4'h0;
  logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b11;
  logic [15:0] rsp_result;
  logic        rsp_zero, rsp_err;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_a, alu_b;
  logic [15:0] alu_r = '0;
  logic        alu_z = 1'b0;
  logic        busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int alu_active = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: registered result, zero only from a SUB giving 0.
  always @(posedge clk) begin
    logic [15:0] diff;
    diff = alu_a - alu_b;
    case (alu_opcode)
      OP_ADD: begin alu_r <= alu_a + alu_b; alu_z <= 1'b0; end
      OP_SUB: begin alu_r <= diff; alu_z <= (diff == 16'h0000); end
      default: alu_z <= 1'b0;
    endcase
  end

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_opcode(req0_opcode), .req0_a(req0_a), .req0_b(req0_b),
    .req1_opcode(req1_opcode), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_r), .alu_zero(alu_z), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int idx, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e.vld    = (idx == 1) ? 2'b10 : 2'b01;
    e.result = 16'h0000;
    e.zero   = 1'b0;
    e.err    = 1'b0;
    if (op == OP_ADD) e.result = a + b;
    else if (op == OP_SUB) begin
      e.result = a - b;
      e.zero   = (e.result == 16'h0000);
    end else e.err = 1'b1;
    return e;
  endfunction

  // Advance one cycle; a response handshake seen before the edge is scored.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (alu_opcode != 4'h0) alu_active++;
    if (rst_n && ((rsp_valid & rsp_ready) != 2'b00)) begin
      if (sb.size() == 0) check("rsp_unexpected", {30'd0, rsp_valid}, 32'd0);
      else begin
        e = sb.pop_front();
        check("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.vld});
        check("rsp_result", {16'd0, rsp_result}, {16'd0, e.result});
        check("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
      end
    end
    @(posedge clk);
    #2;
  endtask

  // Present a request, wait for acceptance, then count cycles to rsp_valid.
  task automatic issue(input int idx, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, output int lat);
    int n;
    if (idx == 0) begin req0_opcode = op; req0_a = a; req0_b = b; end
    else begin req1_opcode = op; req1_a = a; req1_b = b; end
    req_valid[idx] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[idx] && n < 20) begin tick(); n++; end
    check("accept_wait", {31'd0, req_ready[idx]}, 32'd1);
    sb.push_back(mk(idx, op, a, b));
    tick();
    req_valid[idx] = 1'b0;
    lat = 1;
    while (!rsp_valid[idx] && lat < 20) begin tick(); lat++; end
  endtask

  initial begin
    int lat, base, nacc;
    int gidx[4];
    int gcyc[4];

    // Reset values
    tick(); tick();
    check("rst_req_ready", {30'd0, req_ready}, 32'd0);
    check("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    check("rst_outs", {rsp_result, 13'd0, rsp_zero, rsp_err, busy}, 32'd0);
    check("rst_alu", {alu_opcode, alu_a, 12'd0} | {16'd0, alu_b}, 32'd0);
    rst_n = 1'b1;
    tick();

    issue(0, OP_ADD, 16'h0005, 16'h0003, lat);
    check("add_lat", lat, 3);
    check("add_vld", {30'd0, rsp_valid}, 32'd1);
    tick();
    issue(1, OP_SUB, 16'h1234, 16'h1234, lat);
    check("sub_lat", lat, 3);
    tick();
    issue(0, OP_ADD, 16'hFFFF, 16'h0002, lat);
    tick();
    issue(1, OP_SUB, 16'h0000, 16'h0001, lat);
    tick();

    // Illegal opcode: immediate error response, ALU never driven
    base = alu_active;
    issue(0, 4'b0101, 16'h00AA, 16'h0055, lat);
    check("ill_lat", lat, 1);
    tick(); tick();
    check("ill_alu_idle", alu_active - base, 0);

    // Backpressure with a competing request pending
    rsp_ready = 2'b00;
    issue(0, OP_ADD, 16'h0010, 16'h0020, lat);
    check("bp_lat", lat, 3);
    req1_opcode = OP_ADD; req1_a = 16'h0001; req1_b = 16'h0001;
    req_valid[1] = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_req_ready", {30'd0, req_ready}, 32'd0);
      check("bp_rsp", {12'd0, rsp_valid, rsp_result, rsp_zero, rsp_err}, {12'd0, 2'b01, 16'h0030, 2'b00});
      tick();
    end
    rsp_ready = 2'b11;
    issue(1, OP_ADD, 16'h0001, 16'h0001, lat);
    check("bp_next_lat", lat, 3);
    tick();

    // Reset during CAPTURE
    req0_opcode = OP_ADD; req0_a = 16'h0007; req0_b = 16'h0008;
    req_valid = 2'b01;
    #1;
    check("mr_accept", {30'd0, req_ready}, 32'd1);
    tick();
    req_valid = 2'b00;
    check("mr_issue_op", {28'd0, alu_opcode}, {28'd0, OP_ADD});
    tick();
    rst_n = 1'b0;
    #1;
    check("mr_outs", {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, busy, 9'd0}, 32'd0);
    check("mr_alu", {alu_opcode, alu_a, 12'd0} | {16'd0, alu_b}, 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    check("mr_no_rsp", {30'd0, rsp_valid}, 32'd0);

    // Contention straight after reset: alternating grants 4 cycles apart
    req0_opcode = OP_ADD; req0_a = 16'h0001; req0_b = 16'h0002;
    req1_opcode = OP_SUB; req1_a = 16'h0009; req1_b = 16'h0004;
    req_valid = 2'b11;
    #1;
    nacc = 0;
    for (int k = 0; k < 40 && nacc < 4; k++) begin
      if (req_ready != 2'b00) begin
        check("rr_onehot", $countones(req_ready), 1);
        gidx[nacc] = req_ready[1] ? 1 : 0;
        gcyc[nacc] = cyc;
        if (req_ready[1]) sb.push_back(mk(1, req1_opcode, req1_a, req1_b));
        else sb.push_back(mk(0, req0_opcode, req0_a, req0_b));
        nacc++;
      end
      tick();
    end
    req_valid = 2'b00;
    check("rr_count", nacc, 4);
    for (int k = 0; k < 4; k++) check("rr_grant", gidx[k], k % 2);
    for (int k = 1; k < 4; k++) check("rr_interval", gcyc[k] - gcyc[k-1], 4);

    for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 16-bit `alu`. It accepts operation requests over valid/ready handshakes and grants the ALU round-robin. It drives the ALU for the one-cycle registered execution, captures result and zero flag, and returns them on a per-requester response handshake. It sits between the ALU and its clients (execute stage, address/branch unit), so no client drives `alu` ports directly.

## Interface
- `DATA_W`, 16, operand/result width (must match `alu`).
- `OP_W`, 4, opcode width.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 2: bit i = requester i has a request.
- `req_ready` output 2: bit i = request i accepted this cycle.
- `req0_opcode`/`req1_opcode` input OP_W: operation code.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` input DATA_W: operands.
- `rsp_valid` output 2: bit i = response for requester i is present.
- `rsp_ready` input 2: bit i = requester i takes the response.
- `rsp_result` output DATA_W: result (shared bus, qualified by `rsp_valid`).
- `rsp_zero` output 1: ALU zero flag (set only by sub with result 0).
- `rsp_err` output 1: unsupported opcode, no ALU issue.
- `alu_opcode` output OP_W, `alu_a`/`alu_b` output DATA_W: to ALU.
- `alu_result` input DATA_W, `alu_zero` input 1: from ALU.
- `busy` output 1: state != IDLE.

## Operation
- States: IDLE, ISSUE, CAPTURE, RESPOND.
- IDLE: if any `req_valid`, grant one requester: the only valid one, or the one not granted last when both are valid. Raise `req_ready[g]` combinationally in the same cycle. Latch opcode, a, b and g.
  - Legal opcode (ADD 4'b0010, SUB 4'b0011): go to ISSUE.
  - Any other opcode: load result 0, zero 0, err 1, and go to RESPOND.
- ISSUE: drive `alu_opcode`/`alu_a`/`alu_b` from the latched registers. The ALU registers at the end of this cycle. Go to CAPTURE.
- CAPTURE: register `alu_result`/`alu_zero` into the response registers, with err 0. Go to RESPOND.
- RESPOND: hold `rsp_valid[g]`=1 with `rsp_result`/`rsp_zero`/`rsp_err` stable until `rsp_ready[g]`. On the handshake go to IDLE. No new acceptance in this cycle.
- Outside ISSUE, `alu_opcode`=4'b0000 (NOP) and `alu_a`/`alu_b`=0. The ALU holds its result and clears zero.
- `last_grant` updates only on acceptance.
- `req_ready` is 0 in every state except IDLE. Requesters must hold their request stable while `req_valid` is high and not accepted.
- Arithmetic is performed by the ALU only: mod 2^DATA_W wrap, no carry/overflow reporting.

## Timing
- Reset (async assert, synchronous-safe deassert path): state IDLE, `last_grant`=1 so requester 0 wins first.
  - `req_ready`, `rsp_valid`, `rsp_result`, `rsp_zero`, `rsp_err`, `busy`, `alu_opcode`, `alu_a`, `alu_b` all 0.
- Legal op accepted in cycle T: ISSUE in T+1, CAPTURE in T+2, `rsp_valid` high from T+3.
- Illegal op accepted in T: `rsp_valid` high from T+1.
- Minimum issue interval is 4 cycles for legal ops and 2 cycles for illegal ops, with `rsp_ready` tied high.
- Simultaneous `req_valid`=2'b11 in IDLE: exactly one `req_ready` bit is set; never both.
- A request deasserted before acceptance is dropped without side effect.
- Reset mid-operation (any state): the operation is abandoned and no response is produced. The ALU's own register is not reset and is ignored.
- `rsp_ready[i]` for i != g is ignored.

## Structure
- Package `alu_pkg` holds:
  - the opcode constants `OP_NOP`=4'b0000, `OP_ADD`=4'b0010, `OP_SUB`=4'b0011;
  - the state encoding for this FSM;
  - the `DATA_W`/`OP_W` defaults.
- `alu` shares the opcode constants from the same package.
- Sub-module `rr_arb2`: inputs `req_valid[1:0]`, `last_grant`, `en`; outputs a one-hot `grant[1:0]`. It is pure combinational and owns the priority rule.

## Test plan
- Add, no contention: req0 ADD a=16'h0005, b=16'h0003, accepted at T -> `rsp_valid`=2'b01 at T+3, result 16'h0008, zero 0, err 0.
- Sub to zero: req1 SUB a=16'h1234, b=16'h1234 -> `rsp_valid`=2'b10, result 16'h0000, zero 1.
- Wrap-around: ADD 16'hFFFF+16'h0002 -> 16'h0001, zero 0; then SUB 16'h0000-16'h0001 -> 16'hFFFF, zero 0.
- Contention: both requesters valid continuously after reset, `rsp_ready`=2'b11 -> grants alternate 0,1,0,1, and each accept is 4 cycles apart.
- Illegal opcode 4'b0101 on req0 -> `rsp_valid[0]` at T+1, result 0, err 1, `alu_opcode` stays 4'b0000 throughout.
- Backpressure and reset:
  - `rsp_ready` low for 5 cycles in RESPOND -> response fields stable and `req_ready`=0 throughout.
  - Separately, `rst_n` low during CAPTURE -> all outputs 0 immediately, no response ever appears, and the next simultaneous request is granted to requester 0.
